// File: rtl/rggen_multi_word_register.sv
// rtl/rggen_multi_word_register.sv - register spanning several bus words with optional atomic access
//
// Purpose:
//   Maps a DATA_WIDTH = WORDS*BUS_WIDTH register over WORDS consecutive bus
//   words starting at OFFSET_ADDRESS. Decodes the addressed word and drives
//   the bit-field interface with masks positioned on that word's slice.
//
// Configuration macro:
//   RGGEN_MULTI_WORD_ATOMIC_EN
//     undefined: direct mode, every word access goes straight to the bit fields.
//     defined:   atomic mode. Writes to lower words are staged and committed
//                together with the top word. A read of word 0 snapshots the
//                upper words so later word reads return the same value.
//
// Ports:
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   i_register_valid         bus request valid
//   i_register_access        [0]=1 write, 2'b10 read
//   i_register_address       byte address
//   i_register_write_data    write data (one bus word)
//   i_register_strobe        byte strobes
//   o_register_active        address hits one of the words
//   o_register_ready         access completes this cycle
//   o_register_status        2'b00 OKAY, 2'b10 SLVERR
//   o_register_read_data     read data of the addressed word
//   o_register_value         i_bit_field_value passthrough
//   o_bit_field_valid        bit-field access strobe
//   o_bit_field_read_mask    read mask (DATA_WIDTH)
//   o_bit_field_write_mask   write mask, byte strobes expanded (DATA_WIDTH)
//   o_bit_field_write_data   write data (DATA_WIDTH)
//   i_bit_field_read_data    bit-field read data
//   i_bit_field_value        bit-field current value
//   o_staged                 staging buffer holds uncommitted bytes
module rggen_multi_word_register #(
  parameter bit                     READABLE       = 1'b1,
  parameter bit                     WRITABLE       = 1'b1,
  parameter int                     ADDRESS_WIDTH  = 8,
  parameter bit [ADDRESS_WIDTH-1:0] OFFSET_ADDRESS = '0,
  parameter int                     BUS_WIDTH      = 32,
  parameter int                     WORDS          = 2,
  localparam int                    DATA_WIDTH     = WORDS * BUS_WIDTH
)(
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_register_valid,
  input  logic [1:0]               i_register_access,
  input  logic [ADDRESS_WIDTH-1:0] i_register_address,
  input  logic [BUS_WIDTH-1:0]     i_register_write_data,
  input  logic [BUS_WIDTH/8-1:0]   i_register_strobe,
  output logic                     o_register_active,
  output logic                     o_register_ready,
  output logic [1:0]               o_register_status,
  output logic [BUS_WIDTH-1:0]     o_register_read_data,
  output logic [DATA_WIDTH-1:0]    o_register_value,
  output logic                     o_bit_field_valid,
  output logic [DATA_WIDTH-1:0]    o_bit_field_read_mask,
  output logic [DATA_WIDTH-1:0]    o_bit_field_write_mask,
  output logic [DATA_WIDTH-1:0]    o_bit_field_write_data,
  input  logic [DATA_WIDTH-1:0]    i_bit_field_read_data,
  input  logic [DATA_WIDTH-1:0]    i_bit_field_value,
  output logic                     o_staged
);

  localparam int BYTES       = BUS_WIDTH / 8;
  localparam int INDEX_WIDTH = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [INDEX_WIDTH-1:0] TOP_INDEX = INDEX_WIDTH'(WORDS - 1);

  logic                   hit;
  logic [INDEX_WIDTH-1:0] index;
  logic                   access_hit;
  logic                   is_write;
  logic                   is_read;
  logic                   error;
  logic                   do_write;
  logic                   do_read;
  logic [BUS_WIDTH-1:0]   strobe_mask;
  logic [DATA_WIDTH-1:0]  slice_mask;
  logic [DATA_WIDTH-1:0]  write_data_wide;
  logic [DATA_WIDTH-1:0]  write_mask_wide;
  logic [BUS_WIDTH-1:0]   read_slice;

  // Only exact word-aligned addresses inside the window hit.
  always_comb begin
    hit   = 1'b0;
    index = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (i_register_address == (OFFSET_ADDRESS + ADDRESS_WIDTH'(k * BYTES))) begin
        hit   = 1'b1;
        index = INDEX_WIDTH'(k);
      end
    end
  end

  always_comb begin
    strobe_mask = '0;
    for (int i = 0; i < BYTES; i++) begin
      strobe_mask[8*i +: 8] = {8{i_register_strobe[i]}};
    end
  end

  // Place the bus word onto the addressed slice; everything else stays zero.
  always_comb begin
    slice_mask      = '0;
    write_data_wide = '0;
    write_mask_wide = '0;
    read_slice      = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (index == INDEX_WIDTH'(k)) begin
        slice_mask[k*BUS_WIDTH +: BUS_WIDTH]      = '1;
        write_data_wide[k*BUS_WIDTH +: BUS_WIDTH] = i_register_write_data;
        write_mask_wide[k*BUS_WIDTH +: BUS_WIDTH] = strobe_mask;
        read_slice                                = i_bit_field_read_data[k*BUS_WIDTH +: BUS_WIDTH];
      end
    end
  end

  assign access_hit = i_register_valid & hit;
  assign is_write   = i_register_access[0];
  assign is_read    = (i_register_access == 2'b10);
  assign error      = (is_write & !WRITABLE) | (is_read & !READABLE);
  assign do_write   = access_hit & is_write & !error;
  assign do_read    = access_hit & is_read & !error;

  assign o_register_active = hit;
  assign o_register_ready  = access_hit;
  assign o_register_status = (access_hit & error) ? 2'b10 : 2'b00;
  assign o_register_value  = i_bit_field_value;

`ifdef RGGEN_MULTI_WORD_ATOMIC_EN

  logic [DATA_WIDTH-1:0] staging_data;
  logic [DATA_WIDTH-1:0] staging_mask;
  logic [DATA_WIDTH-1:0] snapshot;
  logic [BUS_WIDTH-1:0]  snapshot_slice;
  logic                  stage;
  logic                  commit;
  logic                  read_head;

  assign stage     = do_write & (index != TOP_INDEX);
  assign commit    = do_write & (index == TOP_INDEX);
  assign read_head = do_read & (index == '0);

  always_comb begin
    snapshot_slice = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (index == INDEX_WIDTH'(k)) begin
        snapshot_slice = snapshot[k*BUS_WIDTH +: BUS_WIDTH];
      end
    end
  end

  // staging_data only ever holds bytes whose mask bit is set, so the commit
  // merge with the top word (which lives in a different slice) is a plain OR.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      staging_data <= '0;
      staging_mask <= '0;
      snapshot     <= '0;
    end else begin
      if (stage) begin
        staging_data <= (staging_data & ~write_mask_wide) | (write_data_wide & write_mask_wide);
        staging_mask <= staging_mask | write_mask_wide;
      end else if (commit) begin
        staging_data <= '0;
        staging_mask <= '0;
      end
      if (read_head) begin
        snapshot <= i_bit_field_read_data;
      end
    end
  end

  assign o_bit_field_valid      = commit | read_head;
  assign o_bit_field_read_mask  = read_head ? '1 : '0;
  assign o_bit_field_write_mask = commit ? (staging_mask | write_mask_wide) : '0;
  assign o_bit_field_write_data = commit ? (staging_data | write_data_wide) : '0;
  assign o_register_read_data   = !do_read          ? '0
                                : (index == '0)     ? read_slice
                                                    : snapshot_slice;
  assign o_staged               = |staging_mask;

`else

  logic unused_clock_reset;
  assign unused_clock_reset = i_clk ^ i_rst_n;

  assign o_bit_field_valid      = do_read | do_write;
  assign o_bit_field_read_mask  = do_read ? slice_mask : '0;
  assign o_bit_field_write_mask = do_write ? write_mask_wide : '0;
  assign o_bit_field_write_data = do_write ? write_data_wide : '0;
  assign o_register_read_data   = do_read ? read_slice : '0;
  assign o_staged               = 1'b0;

`endif

endmodule
